// File: rtl/rl_force_output_collector.sv
// Collects per-channel force results into small FIFOs and serializes them
// onto one ready/valid output stream with round-robin arbitration.
module rl_force_output_collector #(
    parameter int DATA_WIDTH        = 32,
    parameter int NUM_EVAL_UNIT     = 4,
    parameter int PARTICLE_ID_WIDTH = 20,
    parameter int FIFO_DEPTH        = 16,
    parameter int FIFO_ADDR_WIDTH   = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [NUM_EVAL_UNIT*PARTICLE_ID_WIDTH-1:0] in_particle_id,
    input  logic [NUM_EVAL_UNIT*DATA_WIDTH-1:0]        in_force_x,
    input  logic [NUM_EVAL_UNIT*DATA_WIDTH-1:0]        in_force_y,
    input  logic [NUM_EVAL_UNIT*DATA_WIDTH-1:0]        in_force_z,
    input  logic [NUM_EVAL_UNIT-1:0]                   in_valid,
    input  logic [NUM_EVAL_UNIT-1:0]                   unit_done,
    output logic [NUM_EVAL_UNIT-1:0]                   almost_full,
    output logic [NUM_EVAL_UNIT-1:0]                   overflow,
    output logic [PARTICLE_ID_WIDTH-1:0]               out_particle_id,
    output logic [DATA_WIDTH-1:0]                      out_force_x,
    output logic [DATA_WIDTH-1:0]                      out_force_y,
    output logic [DATA_WIDTH-1:0]                      out_force_z,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      all_done
);
    localparam int EW = PARTICLE_ID_WIDTH + 3*DATA_WIDTH;
    localparam int LW = (NUM_EVAL_UNIT > 1) ? $clog2(NUM_EVAL_UNIT) : 1;
    localparam int CW = FIFO_ADDR_WIDTH + 1;

    logic [EW-1:0]              r_mem   [NUM_EVAL_UNIT][FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] r_wptr  [NUM_EVAL_UNIT];
    logic [FIFO_ADDR_WIDTH-1:0] r_rptr  [NUM_EVAL_UNIT];
    logic [CW-1:0]              r_count [NUM_EVAL_UNIT];
    logic [NUM_EVAL_UNIT-1:0]   r_done_flags;
    logic [NUM_EVAL_UNIT-1:0]   r_almost_full;
    logic [NUM_EVAL_UNIT-1:0]   r_overflow;
    logic [LW-1:0]              r_last;
    logic [EW-1:0]              r_out_data;
    logic                       r_out_valid;
    logic                       r_all_done;

    logic                       w_load;
    logic                       w_found;
    logic [LW-1:0]              w_sel;
    int unsigned                w_idx;
    logic [NUM_EVAL_UNIT-1:0]   w_push;
    logic [NUM_EVAL_UNIT-1:0]   w_drop;
    logic [NUM_EVAL_UNIT-1:0]   w_pop;
    logic [NUM_EVAL_UNIT-1:0]   w_nonempty;
    logic [NUM_EVAL_UNIT-1:0]   w_flags_next;
    logic [EW-1:0]              w_head;

    assign w_load = !r_out_valid || out_ready;

    // First non-empty channel strictly after the last grant, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        w_idx   = 0;
        for (int unsigned k = 1; k <= NUM_EVAL_UNIT; k++) begin
            w_idx = (32'(r_last) + k) % NUM_EVAL_UNIT;
            if (!w_found && w_nonempty[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx[LW-1:0];
            end
        end
    end

    always_comb begin
        w_push     = '0;
        w_drop     = '0;
        w_pop      = '0;
        w_nonempty = '0;
        for (int unsigned i = 0; i < NUM_EVAL_UNIT; i++) begin
            w_nonempty[i] = (r_count[i] != '0);
            w_push[i]     = in_valid[i] && (r_count[i] < CW'(FIFO_DEPTH));
            w_drop[i]     = in_valid[i] && (r_count[i] == CW'(FIFO_DEPTH));
        end
        for (int unsigned i = 0; i < NUM_EVAL_UNIT; i++) begin
            w_pop[i] = w_load && w_found && (32'(w_sel) == i);
        end
    end

    assign w_head       = r_mem[w_sel][r_rptr[w_sel]];
    assign w_flags_next = start ? '0 : (r_done_flags | unit_done);

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_EVAL_UNIT; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i]] <= {in_particle_id[i*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH],
                                        in_force_x[i*DATA_WIDTH +: DATA_WIDTH],
                                        in_force_y[i*DATA_WIDTH +: DATA_WIDTH],
                                        in_force_z[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_EVAL_UNIT; i++) begin
                r_wptr[i]  <= '0;
                r_rptr[i]  <= '0;
                r_count[i] <= '0;
            end
            r_done_flags  <= '0;
            r_almost_full <= '0;
            r_overflow    <= '0;
            r_last        <= LW'(NUM_EVAL_UNIT-1);
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_all_done    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_EVAL_UNIT; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
                r_count[i]       <= r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
                r_almost_full[i] <= (r_count[i] >= CW'(FIFO_DEPTH-2));
                if (w_drop[i]) r_overflow[i] <= 1'b1;
            end
            if (w_load) begin
                r_out_valid <= w_found;
                if (w_found) begin
                    r_out_data <= w_head;
                    r_last     <= w_sel;
                end
            end
            r_done_flags <= w_flags_next;
            r_all_done   <= (&w_flags_next) && (w_nonempty == '0) && !r_out_valid && (in_valid == '0);
        end
    end

    assign almost_full     = r_almost_full;
    assign overflow        = r_overflow;
    assign out_valid       = r_out_valid;
    assign all_done        = r_all_done;
    assign out_particle_id = r_out_data[EW-1 -: PARTICLE_ID_WIDTH];
    assign out_force_x     = r_out_data[3*DATA_WIDTH-1 -: DATA_WIDTH];
    assign out_force_y     = r_out_data[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign out_force_z     = r_out_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_rl_force_output_collector.sv
// Directed + randomized bench for rl_force_output_collector, checked against
// a queue-based behavioural model of the collector.
`timescale 1ns/1ps
module tb_rl_force_output_collector;
    localparam int DW  = 32;
    localparam int NU  = 4;
    localparam int PW  = 20;
    localparam int DEP = 16;
    localparam int EW  = PW + 3*DW;

    typedef logic [EW-1:0] ent_t;

    logic             clk = 1'b0;
    logic             rst, start, out_ready;
    logic [NU*PW-1:0] in_particle_id;
    logic [NU*DW-1:0] in_force_x, in_force_y, in_force_z;
    logic [NU-1:0]    in_valid, unit_done;
    logic [NU-1:0]    almost_full, overflow;
    logic [PW-1:0]    out_particle_id;
    logic [DW-1:0]    out_force_x, out_force_y, out_force_z;
    logic             out_valid, all_done;

    int n_checks = 0;
    int n_errors = 0;

    ent_t          q [NU][$];
    logic          m_ov;
    ent_t          m_out;
    int            m_last;
    logic [NU-1:0] m_flags, m_af, m_ovf;
    logic          m_ad;

    rl_force_output_collector #(
        .DATA_WIDTH(DW), .NUM_EVAL_UNIT(NU), .PARTICLE_ID_WIDTH(PW),
        .FIFO_DEPTH(DEP), .FIFO_ADDR_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_particle_id(in_particle_id), .in_force_x(in_force_x),
        .in_force_y(in_force_y), .in_force_z(in_force_z),
        .in_valid(in_valid), .unit_done(unit_done),
        .almost_full(almost_full), .overflow(overflow),
        .out_particle_id(out_particle_id), .out_force_x(out_force_x),
        .out_force_y(out_force_y), .out_force_z(out_force_z),
        .out_valid(out_valid), .out_ready(out_ready), .all_done(all_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: one queue per channel, an output slot, and a rotating grant.
    task automatic model_edge();
        int            sz [NU];
        logic [NU-1:0] fl_n;
        logic          any;
        int            idx;
        ent_t          e;
        if (rst) begin
            for (int i = 0; i < NU; i++) q[i].delete();
            m_ov = 0; m_out = '0; m_last = NU-1;
            m_flags = '0; m_af = '0; m_ovf = '0; m_ad = 0;
            return;
        end
        any = 0;
        for (int i = 0; i < NU; i++) begin
            sz[i] = q[i].size();
            if (sz[i] != 0) any = 1;
            m_af[i] = (sz[i] >= DEP-2);
        end
        fl_n = start ? '0 : (m_flags | unit_done);
        m_ad = (fl_n == '1) && !any && !m_ov && (in_valid == '0);
        m_flags = fl_n;
        if (!m_ov || out_ready) begin
            m_ov = 0;
            for (int k = 1; k <= NU; k++) begin
                idx = (m_last + k) % NU;
                if (!m_ov && sz[idx] != 0) begin
                    e = q[idx].pop_front();
                    m_out = e; m_ov = 1; m_last = idx;
                end
            end
        end
        for (int i = 0; i < NU; i++) begin
            if (in_valid[i]) begin
                if (sz[i] < DEP)
                    q[i].push_back({in_particle_id[i*PW +: PW], in_force_x[i*DW +: DW],
                                    in_force_y[i*DW +: DW], in_force_z[i*DW +: DW]});
                else
                    m_ovf[i] = 1;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("out_id", out_particle_id, m_out[EW-1 -: PW]);
        chk("out_x", out_force_x, m_out[3*DW-1 -: DW]);
        chk("out_y", out_force_y, m_out[2*DW-1 -: DW]);
        chk("out_z", out_force_z, m_out[DW-1:0]);
        chk("almost_full", almost_full, m_af);
        chk("overflow", overflow, m_ovf);
        chk("all_done", all_done, m_ad);
    endtask

    task automatic set_ch(input int i, input logic [PW-1:0] id, input logic [DW-1:0] x,
                          input logic [DW-1:0] y, input logic [DW-1:0] z);
        in_particle_id[i*PW +: PW] = id;
        in_force_x[i*DW +: DW] = x;
        in_force_y[i*DW +: DW] = y;
        in_force_z[i*DW +: DW] = z;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NU; i++)
            set_ch(i, PW'($urandom), $urandom, $urandom, $urandom);
    endtask

    task automatic idle_inputs();
        start = 0; in_valid = '0; unit_done = '0;
        in_particle_id = '0; in_force_x = '0; in_force_y = '0; in_force_z = '0;
    endtask

    task automatic do_reset();
        rst = 1; cycle(); rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1; out_ready = 0;

        // Reset with random inputs held two cycles.
        rand_data(); in_valid = NU'($urandom); unit_done = NU'($urandom); out_ready = 1;
        cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_all_done", all_done, 0);
        rand_data(); in_valid = NU'($urandom);
        cycle();
        rst = 0; idle_inputs();
        cycle();

        // Single entry on channel 2.
        out_ready = 1; in_valid = 4'b0100;
        set_ch(2, 20'h00123, 32'h3F800000, 32'h40000000, 32'h40400000);
        cycle();
        chk("single_lat0", out_valid, 0);
        idle_inputs();
        cycle();
        chk("single_valid", out_valid, 1);
        chk("single_id", out_particle_id, 20'h00123);
        chk("single_x", out_force_x, 32'h3F800000);
        cycle();
        chk("single_gone", out_valid, 0);

        // Fairness from reset: 0,1,2,3.
        do_reset();
        out_ready = 1; in_valid = '1;
        for (int i = 0; i < NU; i++) set_ch(i, PW'(32'h200 + i), $urandom, $urandom, $urandom);
        cycle();
        idle_inputs();
        for (int i = 0; i < NU; i++) begin
            cycle();
            chk("fair_id", out_particle_id, PW'(32'h200 + i));
        end
        cycle();

        // Overflow on channel 0 with a stalled sink.
        do_reset();
        out_ready = 0;
        for (int n = 0; n < 18; n++) begin
            in_valid = 4'b0001;
            set_ch(0, PW'(32'h100 + n), $urandom, $urandom, $urandom);
            cycle();
        end
        idle_inputs();
        chk("ovf_flag", overflow[0], 1);
        chk("ovf_af", almost_full[0], 1);
        out_ready = 1;
        for (int n = 0; n < 17; n++) begin
            chk("ovf_order", out_particle_id, PW'(32'h100 + n));
            cycle();
        end
        chk("ovf_drained", out_valid, 0);
        chk("ovf_sticky", overflow[0], 1);

        // Done tracking with three queued entries.
        do_reset();
        out_ready = 0;
        for (int n = 0; n < 3; n++) begin
            in_valid = 4'b0010; rand_data(); cycle();
        end
        idle_inputs(); unit_done = '1; cycle();
        unit_done = '0; out_ready = 1;
        for (int n = 0; n < 20 && out_valid; n++) begin
            chk("done_pending", all_done, 0);
            cycle();
        end
        cycle();
        chk("done_set", all_done, 1);
        start = 1; cycle(); start = 0;
        chk("done_cleared", all_done, 0);

        // Mid-operation reset drops everything.
        out_ready = 0;
        for (int n = 0; n < 5; n++) begin
            in_valid = '1; rand_data(); cycle();
        end
        idle_inputs();
        chk("mid_busy", out_valid, 1);
        do_reset();
        out_ready = 1;
        for (int n = 0; n < 6; n++) begin
            cycle();
            chk("mid_silent", out_valid, 0);
        end

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rand_data();
            in_valid  = NU'($urandom);
            out_ready = ((n / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            unit_done = ($urandom_range(0, 9) == 0) ? NU'($urandom) : '0;
            start     = ($urandom_range(0, 29) == 0);
            cycle();
        end
        idle_inputs(); unit_done = '1; out_ready = 1;
        cycle();
        unit_done = '0;
        for (int n = 0; n < 80; n++) cycle();
        chk("rand_final_done", all_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rl_force_output_collector.md
RL_FORCE_OUTPUT_COLLECTOR -- requirements
Module: rl_force_output_collector

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, IEEE-754 single force word width.
REQ-002 SHALL provide parameter NUM_EVAL_UNIT, default 4, number of evaluation-unit output channels.
REQ-003 SHALL provide parameter PARTICLE_ID_WIDTH, default 20, particle ID width.
REQ-004 SHALL provide parameter FIFO_DEPTH, default 16, entries per channel FIFO (power of 2).
REQ-005 SHALL provide parameter FIFO_ADDR_WIDTH, default 4, log2(FIFO_DEPTH).
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-007 SHALL provide these ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; clears latched done flags
- in_particle_id  in  NUM_EVAL_UNIT*PARTICLE_ID_WIDTH  per-channel particle ID, channel i at slice i
- in_force_x / in_force_y / in_force_z  in  NUM_EVAL_UNIT*DATA_WIDTH  per-channel force components
- in_valid  in  NUM_EVAL_UNIT  per-channel valid; upstream cannot stall
- unit_done  in  NUM_EVAL_UNIT  per-channel done level or pulse
- almost_full  out  NUM_EVAL_UNIT  channel FIFO count >= FIFO_DEPTH-2
- overflow  out  NUM_EVAL_UNIT  sticky; channel dropped an entry
- out_particle_id  out  PARTICLE_ID_WIDTH  serialized ID
- out_force_x / out_force_y / out_force_z  out  DATA_WIDTH  serialized components
- out_valid  out  1  output register holds data
- out_ready  in  1  downstream accepts when high with out_valid
- all_done  out  1  all channels done and fully drained

Function
REQ-008 SHALL contain one FIFO per channel; entry = {ID, X, Y, Z}; occupancy counter 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
REQ-009 SHALL write channel i FIFO on an edge where in_valid[i]=1 and count[i] < FIFO_DEPTH, evaluated from the registered count at cycle start.
REQ-010 SHALL drop the entry and set overflow[i]=1 when in_valid[i]=1 and count[i]=FIFO_DEPTH, even if the same cycle pops channel i; overflow holds until rst.
REQ-011 SHALL load the output register when out_valid=0 or out_ready=1, from the FIFO selected by round-robin, popping that FIFO on the same edge.
REQ-012 SHALL choose round-robin as the first non-empty channel strictly after the last granted channel, cyclically; after reset, last-granted = NUM_EVAL_UNIT-1, so channel 0 has first priority.
REQ-013 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-014 SHALL deassert out_valid after an accepted transfer when no FIFO is non-empty.
REQ-015 SHALL apply minimum latency as follows: input sampled at edge k gives out_valid=1 after edge k+1; there is no FIFO bypass.
REQ-016 SHALL allow a FIFO write and a pop on the same channel in one edge; the count is then unchanged.
REQ-017 SHALL latch unit_done[i] into a sticky flag; start=1 clears all flags on that edge, and start takes priority over a simultaneous unit_done.
REQ-018 SHALL register all_done: high after the edge where all flags are set, all FIFOs are empty, out_valid=0, and in_valid=0; low otherwise.
REQ-019 SHALL leave FIFO contents, out_* and overflow unaffected by start.
REQ-020 SHALL register almost_full from the count, updated the edge after the count changes.

Reset
REQ-021 SHALL apply these values on an edge with rst=1:
- out_valid, out_particle_id, out_force_x/y/z, all_done, almost_full, overflow = 0
- all counts and pointers = 0
- done flags cleared
- last-granted = NUM_EVAL_UNIT-1
REQ-022 SHALL discard all buffered data on rst asserted mid-operation, with no output emitted after it.

Verification
REQ-023 SHALL pass reset: rst held 2 cycles with random inputs -> every output 0 after first rst edge.
REQ-024 SHALL pass single entry: in_valid=4'b0100, ID 20'h00123, X 32'h3F800000, out_ready=1 -> out_valid=1 after second edge with ID 20'h00123, X 32'h3F800000; out_valid=0 one cycle later.
REQ-025 SHALL pass fairness: all four channels valid in one cycle, out_ready=1 -> outputs from channels 0,1,2,3 on four consecutive cycles.
REQ-026 SHALL pass overflow: out_ready=0, channel 0 valid for 18 consecutive cycles ->
- 1 entry in output register, 16 in FIFO, 1 dropped
- almost_full[0]=1 once count reaches 14
- overflow[0]=1
- then out_ready=1 -> 17 entries in input order, overflow[0] stays 1
REQ-027 SHALL pass done: unit_done=4'b1111 pulse while 3 entries queued -> all_done=0 until the last entry is accepted, then 1; start pulse -> all_done=0 on the next edge.
REQ-028 SHALL pass mid-operation reset: rst with non-empty FIFOs and out_valid=1 -> out_valid=0, counts 0, overflow 0, nothing emitted afterwards.
